dmem_responder: RTL and testbench

- Data-memory target for the pipeline's memory stage: answers the load/store requests the stage issues.
- Replaces the zero-latency memory model with a handshaked responder that has a programmable number of wait states.
- Handles RISC-V byte, half and word sizes, including load sign/zero extension and byte-lane stores.
- Flags misaligned, unsupported-size and out-of-range accesses with an error response instead of touching memory.

---
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline memory stage: a handshaked
// load/store target with programmable wait states, RISC-V byte/half/word
// sizes, load extension, byte-lane stores and error responses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        unsgn;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [31:0]      rdata_d;
  logic             err_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      cur_word;
  logic             acc_err;
  logic [31:0]      load_val;
  logic [31:0]      store_word;
  logic             mem_we;
  logic [31:0]      byte_shift;
  logic [31:0]      half_shift;

  assign idx      = req_q.addr[IDX_W+1:2];
  assign cur_word = mem[idx];

  // Reject illegal size, misalignment and out-of-range word index
  always_comb begin
    acc_err = 1'b0;
    case (req_q.size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = req_q.addr[0];
      2'b10:   acc_err = |req_q.addr[1:0];
      default: acc_err = 1'b1;
    endcase
    if (req_q.addr[31:2] >= 30'(DEPTH_WORDS)) begin
      acc_err = 1'b1;
    end
  end

  // Select the addressed lane(s) and extend to 32 bits
  always_comb begin
    byte_shift = cur_word >> {req_q.addr[1:0], 3'b000};
    half_shift = cur_word >> {req_q.addr[1], 4'b0000};
    load_val   = cur_word;
    case (req_q.size)
      2'b00: load_val = req_q.unsgn ? {24'h0, byte_shift[7:0]}
                                    : {{24{byte_shift[7]}}, byte_shift[7:0]};
      2'b01: load_val = req_q.unsgn ? {16'h0, half_shift[15:0]}
                                    : {{16{half_shift[15]}}, half_shift[15:0]};
      default: load_val = cur_word;
    endcase
  end

  // Merge store data into the addressed lanes, keeping the other bytes
  always_comb begin
    store_word = cur_word;
    case (req_q.size)
      2'b00:   store_word[{req_q.addr[1:0], 3'b000} +: 8]  = req_q.wdata[7:0];
      2'b01:   store_word[{req_q.addr[1], 4'b0000} +: 16]  = req_q.wdata[15:0];
      default: store_word = req_q.wdata;
    endcase
  end

  // Next-state, request latch, wait counter and access execution
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = resp_rdata;
    err_d   = resp_err;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          req_d.size  = req_size;
          req_d.unsgn = req_unsigned;
          cnt_d       = CNT_LOAD;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || req_q.we) ? 32'h0 : load_val;
          mem_we  = req_q.we && !acc_err;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      req_ready  <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
      resp_valid <= (state_d == ST_RESP);
    end
  end

  // Storage array; contents survive reset, a reset edge blocks the commit
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan cases,
// reset-in-flight cases and a randomized back-to-back run against a
// byte-array reference model. A second LATENCY=1 instance checks timing.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned L     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        l1_valid, l1_we, l1_unsigned;
  logic [31:0] l1_addr, l1_wdata;
  logic [1:0]  l1_size;
  logic        l1_ready, l1_resp_valid, l1_err, l1_busy;
  logic [31:0] l1_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] mem_m [DEPTH*4];

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
  } exp_t;
  exp_t q[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(l1_valid), .req_we(l1_we),
    .req_addr(l1_addr), .req_wdata(l1_wdata), .req_size(l1_size),
    .req_unsigned(l1_unsigned), .req_ready(l1_ready), .resp_valid(l1_resp_valid),
    .resp_rdata(l1_rdata), .resp_err(l1_err), .busy(l1_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: memory as a little-endian byte array
  function automatic void ref_access(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [1:0] size,
                                     input logic uns, output logic [31:0] rd,
                                     output logic er);
    int nbytes;
    int base;
    logic [31:0] tmp;
    er = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
         (size == 2'b10 && addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    rd = 32'h0;
    if (er) return;
    nbytes = 1 << size;
    base   = int'(addr);
    if (we) begin
      for (int i = 0; i < nbytes; i++) begin
        tmp = wdata >> (8 * i);
        mem_m[base + i] = tmp[7:0];
      end
    end else begin
      for (int i = 0; i < nbytes; i++) rd = rd | (32'(mem_m[base + i]) << (8 * i));
      if (!uns && nbytes == 1 && rd[7])  rd = rd | 32'hFFFF_FF00;
      if (!uns && nbytes == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
    end
  endfunction

  task automatic rand_req();
    int sel;
    sel          = int'($urandom_range(0, 15));
    req_we       = 1'($urandom_range(0, 1));
    req_wdata    = $urandom;
    req_unsigned = 1'($urandom_range(0, 1));
    req_size     = (sel == 1) ? 2'b11 : 2'($urandom_range(0, 2));
    req_addr     = (sel == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
    if (sel >= 8 && req_size != 2'b11) req_addr = req_addr & ~((32'd1 << req_size) - 32'd1);
  endtask

  // One full transaction on the LATENCY=L instance with cycle-exact checks
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] got, output logic got_err);
    logic [31:0] erd;
    logic        eer;
    int          n;
    got = 32'h0;
    got_err = 1'b0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    ref_access(we, addr, wdata, size, uns, erd, eer);
    @(posedge clk);
    for (int k = 1; k <= int'(L) + 2; k++) begin
      @(negedge clk);
      if (k <= int'(L)) begin
        rand_req();
        req_valid = 1'($urandom_range(0, 1));
        check("wait_phase", 32'({resp_valid, req_ready, busy}), 32'b001);
      end else if (k == int'(L) + 1) begin
        req_valid = 1'b0;
        check("resp_phase", 32'({resp_valid, req_ready, busy}), 32'b101);
        check("resp_err", 32'(resp_err), 32'(eer));
        check("resp_rdata", resp_rdata, erd);
        got = resp_rdata;
        got_err = resp_err;
      end else begin
        check("idle_phase", 32'({resp_valid, req_ready, busy}), 32'b010);
      end
    end
  endtask

  initial begin
    logic [31:0] got, erd;
    logic        gerr, eer, exp_v, exp_ready;
    int          idle_at, last_acc;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b10; req_unsigned = 1'b0;
    l1_valid = 1'b0; l1_we = 1'b0; l1_addr = '0; l1_wdata = '0;
    l1_size = 2'b10; l1_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_busy_valid", 32'({req_ready, busy, resp_valid}), 32'b100);
    check("rst_rdata_err", 32'({resp_rdata != 32'h0, resp_err}), 32'b00);
    reset = 1'b0;

    // LATENCY=1 instance: response on the edge after the accept edge
    @(negedge clk);
    l1_valid = 1'b1; l1_we = 1'b1; l1_addr = 32'h8; l1_wdata = 32'hCAFE_F00D; l1_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    l1_valid = 1'b0;
    check("l1_wait", 32'({l1_resp_valid, l1_ready, l1_busy}), 32'b001);
    @(negedge clk);
    check("l1_resp", 32'({l1_resp_valid, l1_ready, l1_busy, l1_err}), 32'b1010);
    @(negedge clk);
    check("l1_idle", 32'({l1_resp_valid, l1_ready, l1_busy}), 32'b010);
    l1_valid = 1'b1; l1_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    l1_valid = 1'b0;
    @(negedge clk);
    check("l1_load_valid", 32'(l1_resp_valid), 32'd1);
    check("l1_load_rdata", l1_rdata, 32'hCAFE_F00D);

    // Fill the array so the model and DUT start from known contents
    for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, got, gerr);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, got, gerr);
    check("st_word_rdata0", got, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, got, gerr);
    check("ld_word", got, 32'hDEADBEEF);
    issue(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, got, gerr);
    issue(1'b1, 32'h21, 32'h0000_0080, 2'b00, 1'b0, got, gerr);
    issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, got, gerr);
    check("byte_merge", got, 32'h11228044);
    issue(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, got, gerr);
    check("ld_byte_s", got, 32'hFFFFFF80);
    issue(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, got, gerr);
    check("ld_byte_u", got, 32'h00000080);
    issue(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, got, gerr);
    check("ld_half_s", got, 32'h00001122);

    issue(1'b0, 32'h23, 32'h0, 2'b01, 1'b0, got, gerr);
    check("err_half_mis", 32'({gerr, got != 32'h0}), 32'b10);
    issue(1'b1, 32'h12, 32'hFFFF_FFFF, 2'b10, 1'b0, got, gerr);
    check("err_word_mis", 32'({gerr, got != 32'h0}), 32'b10);
    issue(1'b1, 32'h20, 32'hFFFF_FFFF, 2'b11, 1'b0, got, gerr);
    check("err_size11", 32'({gerr, got != 32'h0}), 32'b10);
    issue(1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 2'b10, 1'b0, got, gerr);
    check("err_range", 32'({gerr, got != 32'h0}), 32'b10);
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, got, gerr);
    check("err_kept_10", got, 32'hDEADBEEF);
    issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, got, gerr);
    check("err_kept_20", got, 32'h11228044);

    // Reset while a store waits: store dropped; reset also beats a new request
    issue(1'b1, 32'h30, 32'h0, 2'b10, 1'b0, got, gerr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_size = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_we = 1'b1; req_addr = 32'h34; req_wdata = 32'hAA; req_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    check("rst_wait_idle", 32'({resp_valid, req_ready, busy}), 32'b010);
    for (int k = 0; k < int'(L) + 2; k++) begin
      @(negedge clk);
      check("rst_wait_novalid", 32'({resp_valid, busy}), 32'b00);
    end
    issue(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, got, gerr);
    check("rst_wait_dropped", got, 32'h0);

    // Reset while responding: the store has already committed
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_size = 2'b00;
    ref_access(1'b1, 32'h30, 32'h55, 2'b00, 1'b0, erd, eer);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (int'(L)) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_resp_idle", 32'({resp_valid, req_ready, busy}), 32'b010);
    issue(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, got, gerr);
    check("rst_resp_kept", got, 32'h55);

    // Randomized run with req_valid held high and requests changing every cycle
    @(negedge clk);
    idle_at  = cyc;
    last_acc = -1;
    for (int t = 0; t < 300; t++) begin
      exp_ready = (cyc >= idle_at);
      check("b2b_ready", 32'(req_ready), 32'(exp_ready));
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("b2b_valid", 32'(resp_valid), 32'(exp_v));
      if (exp_v) begin
        check("b2b_rdata", resp_rdata, q[0].rd);
        check("b2b_err", 32'(resp_err), 32'(q[0].er));
        void'(q.pop_front());
      end
      rand_req();
      req_valid = (t < 300 - int'(L) - 4);
      if (exp_ready && req_valid) begin
        if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(L + 2));
        last_acc = cyc;
        ref_access(req_we, req_addr, req_wdata, req_size, req_unsigned, erd, eer);
        q.push_back('{due: cyc + int'(L) + 1, rd: erd, er: eer});
        idle_at = cyc + int'(L) + 2;
      end
      @(negedge clk);
    end
    check("b2b_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
